// File: rtl/prog_clk_divider_pkg.sv
// prog_clk_divider_pkg: shared divisor constants and width helpers for the clock-enable generator
package prog_clk_divider_pkg;
  localparam int unsigned DIV_1HZ   = 100_000_000;
  localparam int unsigned DIV_1KHZ  = 100_000;
  localparam int unsigned DIV_50MHZ = 2;
  localparam int          CNT_W_DEF = 27;
  function automatic int clog2(input int unsigned n);
    int r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) r++;
    return r;
  endfunction
  function automatic int ch_w(input int unsigned n);
    return (n > 1) ? clog2(n) : 1;
  endfunction
endpackage

// File: rtl/prog_clk_divider_channel.sv
// prog_clk_divider_channel: one divider channel with shadow divisor applied at period boundaries
module prog_clk_divider_channel import prog_clk_divider_pkg::*; #(
  parameter int          CNT_W       = CNT_W_DEF,
  parameter int unsigned DEFAULT_DIV = DIV_1HZ
) (
  input  logic             clk_100MHz,
  input  logic             reset,
  input  logic             en,
  input  logic             sync,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_div,
  output logic             pending,
  output logic             tick,
  output logic             clk_out
);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  logic [CNT_W-1:0] cnt, cnt_n, a, a_n, shadow;
  logic [CNT_W:0]   half;
  logic run, run_n, go, bnd, apply;
  // run is low for the first cycle after a stop, so a restart always begins at cnt 0
  always_comb begin
    go    = en && a != '0;
    bnd   = !go || !run || sync || cnt == a - ONE;
    apply = pending && bnd;
    cnt_n = bnd ? '0 : cnt + ONE;
    a_n   = apply ? shadow : a;
    run_n = go && a_n != '0;
    half  = ({1'b0, a_n} + (CNT_W+1)'(1)) >> 1;
  end
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      cnt     <= '0;
      a       <= CNT_W'(DEFAULT_DIV);
      shadow  <= CNT_W'(DEFAULT_DIV);
      pending <= 1'b0;
      run     <= 1'b0;
      tick    <= 1'b0;
      clk_out <= 1'b0;
    end else begin
      cnt     <= cnt_n;
      a       <= a_n;
      run     <= run_n;
      pending <= wr || (pending && !apply);
      tick    <= run_n && cnt_n == a_n - ONE;
      clk_out <= run_n && {1'b0, cnt_n} < half;
      if (wr) shadow <= wr_div;
    end
  end
endmodule

// File: rtl/prog_clk_divider.sv
// prog_clk_divider: multi-channel programmable clock-enable generator on the 100 MHz board clock
module prog_clk_divider import prog_clk_divider_pkg::*; #(
  parameter int          NUM_CH      = 4,
  parameter int          CNT_W       = CNT_W_DEF,
  parameter int unsigned DEFAULT_DIV = DIV_1HZ
) (
  input  logic                      clk_100MHz,
  input  logic                      reset,
  input  logic [NUM_CH-1:0]         ch_en,
  input  logic                      sync,
  input  logic                      wr_valid,
  input  logic [ch_w(NUM_CH)-1:0]   wr_ch,
  input  logic [CNT_W-1:0]          wr_div,
  output logic [NUM_CH-1:0]         pending,
  output logic [NUM_CH-1:0]         tick,
  output logic [NUM_CH-1:0]         clk_out
);
  localparam int CH_W = ch_w(NUM_CH);
  // out-of-range wr_ch matches no channel and is dropped
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    prog_clk_divider_channel #(.CNT_W(CNT_W), .DEFAULT_DIV(DEFAULT_DIV)) u_ch (
      .clk_100MHz (clk_100MHz),
      .reset      (reset),
      .en         (ch_en[g]),
      .sync       (sync),
      .wr         (wr_valid && wr_ch == CH_W'(g)),
      .wr_div     (wr_div),
      .pending    (pending[g]),
      .tick       (tick[g]),
      .clk_out    (clk_out[g])
    );
  end
endmodule

// File: tb/tb_prog_clk_divider.sv
// tb_prog_clk_divider: directed self-checking bench for prog_clk_divider
module tb_prog_clk_divider;
  localparam int NUM_CH = 3;
  localparam int CNT_W  = 27;
  logic clk_100MHz = 1'b0;
  logic reset = 1'b1, sync = 1'b0, wr_valid = 1'b0;
  logic [NUM_CH-1:0] ch_en = '0;
  logic [1:0] wr_ch = '0;
  logic [CNT_W-1:0] wr_div = '0;
  logic [NUM_CH-1:0] pending, tick, clk_out;
  int n_tests = 0, n_fail = 0;
  prog_clk_divider #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEFAULT_DIV(6)) dut (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .ch_en      (ch_en),
    .sync       (sync),
    .wr_valid   (wr_valid),
    .wr_ch      (wr_ch),
    .wr_div     (wr_div),
    .pending    (pending),
    .tick       (tick),
    .clk_out    (clk_out)
  );
  always #5 clk_100MHz = ~clk_100MHz;
  task automatic step();
    @(posedge clk_100MHz);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
      $error("check %s", tag);
    end
  endtask
  task automatic start_ch(input int ch, input int n);
    ch_en[ch] = 1'b0;
    step();
    wr_valid = 1'b1; wr_ch = 2'(ch); wr_div = CNT_W'(n);
    step();
    chk($sformatf("pend_set ch%0d n%0d", ch, n), 32'(pending[ch]), 1);
    wr_valid = 1'b0;
    step();
    chk($sformatf("pend_clr ch%0d n%0d", ch, n), 32'(pending[ch]), 0);
    ch_en[ch] = 1'b1;
    step();
    chk($sformatf("start_clk ch%0d n%0d", ch, n), 32'(clk_out[ch]), 32'(n != 0));
    chk($sformatf("start_tick ch%0d n%0d", ch, n), 32'(tick[ch]), 32'(n == 1));
  endtask
  initial begin
    step(); step();
    chk("rst_pending", 32'(pending), 0);
    chk("rst_tick", 32'(tick), 0);
    chk("rst_clk", 32'(clk_out), 0);
    // default divisor 6 on ch0
    reset = 1'b0; ch_en = 3'b001;
    for (int i = 0; i < 12; i++) begin
      step();
      chk($sformatf("n6_clk %0d", i), 32'(clk_out), 32'((i % 6) < 3));
      chk($sformatf("n6_tick %0d", i), 32'(tick), 32'((i % 6) == 5));
    end
    start_ch(0, 5);
    for (int i = 1; i < 10; i++) begin
      step();
      chk($sformatf("n5_clk %0d", i), 32'(clk_out[0]), 32'((i % 5) < 3));
      chk($sformatf("n5_tick %0d", i), 32'(tick[0]), 32'((i % 5) == 4));
    end
    start_ch(0, 2);
    for (int i = 1; i < 4; i++) begin
      step();
      chk($sformatf("n2_clk %0d", i), 32'(clk_out[0]), 32'((i % 2) == 0));
      chk($sformatf("n2_tick %0d", i), 32'(tick[0]), 32'((i % 2) == 1));
    end
    start_ch(0, 1);
    for (int i = 1; i < 3; i++) begin
      step();
      chk($sformatf("n1_clk %0d", i), 32'(clk_out[0]), 1);
      chk($sformatf("n1_tick %0d", i), 32'(tick[0]), 1);
    end
    start_ch(0, 0);
    step(); step();
    chk("n0_clk", 32'(clk_out[0]), 0);
    chk("n0_tick", 32'(tick[0]), 0);
    wr_valid = 1'b1; wr_ch = 2'd0; wr_div = CNT_W'(3);
    step();
    chk("n0_wr_pend", 32'(pending[0]), 1);
    wr_valid = 1'b0;
    step();
    chk("n0_apply_pend", 32'(pending[0]), 0);
    chk("n0_apply_clk", 32'(clk_out[0]), 0);
    step();
    chk("n0_restart_clk", 32'(clk_out[0]), 1);
    chk("n0_restart_tick", 32'(tick[0]), 0);
    ch_en[0] = 1'b0;
    // divisor change on ch1 from 10
    start_ch(1, 10);
    step(); step(); step();
    wr_valid = 1'b1; wr_ch = 2'd1; wr_div = CNT_W'(4);
    step();
    chk("chg_pend cnt4", 32'(pending[1]), 1);
    wr_valid = 1'b0;
    for (int k = 5; k < 10; k++) begin
      step();
      chk($sformatf("chg_pend cnt%0d", k), 32'(pending[1]), 1);
    end
    chk("chg_tick cnt9", 32'(tick[1]), 1);
    step();
    chk("chg_applied_pend", 32'(pending[1]), 0);
    chk("chg_applied_clk", 32'(clk_out[1]), 1);
    chk("chg_applied_tick", 32'(tick[1]), 0);
    for (int i = 1; i < 9; i++) begin
      step();
      chk($sformatf("n4_clk %0d", i), 32'(clk_out[1]), 32'((i % 4) < 2));
      chk($sformatf("n4_tick %0d", i), 32'(tick[1]), 32'((i % 4) == 3));
    end
    step(); step(); step();
    chk("at_tick tick", 32'(tick[1]), 1);
    wr_valid = 1'b1; wr_ch = 2'd1; wr_div = CNT_W'(7);
    step();
    chk("at_tick pend", 32'(pending[1]), 1);
    chk("at_tick clk", 32'(clk_out[1]), 1);
    wr_valid = 1'b0;
    step(); step(); step();
    chk("at_tick old period tick", 32'(tick[1]), 1);
    chk("at_tick still pend", 32'(pending[1]), 1);
    step();
    chk("at_tick applied pend", 32'(pending[1]), 0);
    for (int i = 1; i < 7; i++) begin
      step();
      chk($sformatf("n7_clk %0d", i), 32'(clk_out[1]), 32'(i < 4));
      chk($sformatf("n7_tick %0d", i), 32'(tick[1]), 32'(i == 6));
    end
    // back-to-back writes, last wins
    step();
    wr_valid = 1'b1; wr_ch = 2'd1; wr_div = CNT_W'(8);
    step();
    wr_div = CNT_W'(3);
    step();
    chk("b2b pend", 32'(pending[1]), 1);
    wr_valid = 1'b0;
    step(); step(); step(); step();
    chk("b2b tick n7", 32'(tick[1]), 1);
    step();
    chk("b2b applied pend", 32'(pending[1]), 0);
    for (int i = 1; i < 6; i++) begin
      step();
      chk($sformatf("n3_clk %0d", i), 32'(clk_out[1]), 32'((i % 3) < 2));
      chk($sformatf("n3_tick %0d", i), 32'(tick[1]), 32'((i % 3) == 2));
    end
    wr_valid = 1'b1; wr_ch = 2'd3; wr_div = CNT_W'(5);
    step();
    chk("bad_ch pend", 32'(pending), 0);
    wr_valid = 1'b0;
    for (int i = 1; i < 6; i++) begin
      step();
      chk($sformatf("bad_ch n3_clk %0d", i), 32'(clk_out), 32'({1'b0, (i % 3) < 2, 1'b0}));
      chk($sformatf("bad_ch n3_tick %0d", i), 32'(tick[1]), 32'((i % 3) == 2));
    end
    // sync phase alignment
    start_ch(0, 4);
    start_ch(1, 6);
    step();
    sync = 1'b1;
    step();
    sync = 1'b0;
    chk("sync clk", 32'(clk_out), 32'(3'b011));
    chk("sync tick", 32'(tick), 0);
    for (int i = 1; i < 12; i++) begin
      step();
      chk($sformatf("sync ch0 %0d", i), 32'({tick[0], clk_out[0]}), 32'({(i % 4) == 3, (i % 4) < 2}));
      chk($sformatf("sync ch1 %0d", i), 32'({tick[1], clk_out[1]}), 32'({(i % 6) == 5, (i % 6) < 3}));
    end
    // reset mid-period with a write in flight
    wr_valid = 1'b1; wr_ch = 2'd0; wr_div = CNT_W'(9); reset = 1'b1;
    step();
    wr_valid = 1'b0; reset = 1'b0;
    chk("midrst pend", 32'(pending), 0);
    chk("midrst tick", 32'(tick), 0);
    chk("midrst clk", 32'(clk_out), 0);
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("postrst ch0 %0d", i), 32'({tick[0], clk_out[0]}), 32'({(i % 6) == 5, (i % 6) < 3}));
    end
    ch_en[0] = 1'b0;
    step();
    chk("dis clk", 32'(clk_out[0]), 0);
    chk("dis tick", 32'(tick[0]), 0);
    ch_en[0] = 1'b1;
    step();
    chk("reen clk", 32'(clk_out[0]), 1);
    for (int i = 1; i < 6; i++) begin
      step();
      chk($sformatf("reen tick %0d", i), 32'(tick[0]), 32'(i == 5));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
